ctrl_pipe: RTL

- Receiving end of the main control decoder's output bundle.
- Carries the decoded control word and register fields through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
- Detects load-use hazards (stall), inserts bubbles on stall or flush, and generates EX-stage forwarding selects.
- Keeps a saturating stall counter for performance debug.

---
 rtl/ctrl_pipe_if.sv | 40 ++++
 rtl/ctrl_pipe.sv | 118 +++++++++++
 2 files changed

// File: rtl/ctrl_pipe_if.sv
// Decoder-side bundle into the control pipeline and the EX/MEM/WB controls coming back out.
// master drives the ID-stage fields and flush; slave (the pipeline) drives stall, forwarding and stage controls.
interface ctrl_pipe_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid_i;
    logic [10:0]      id_ctrl_i;
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic [REG_W-1:0] id_rd_i;
    logic             flush_i;

    logic             stall_o;
    logic             ex_alu_src_o;
    logic [2:0]       ex_alu_op_o;
    logic             ex_branch_o;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic             mem_mem_write_o;
    logic             mem_mem_read_o;
    logic             wb_reg_write_o;
    logic             wb_memto_reg_o;
    logic [REG_W-1:0] wb_dst_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_valid_i, id_ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
        input  stall_o, ex_alu_src_o, ex_alu_op_o, ex_branch_o, fwd_a_o, fwd_b_o,
               mem_mem_write_o, mem_mem_read_o, wb_reg_write_o, wb_memto_reg_o,
               wb_dst_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
        output stall_o, ex_alu_src_o, ex_alu_op_o, ex_branch_o, fwd_a_o, fwd_b_o,
               mem_mem_write_o, mem_mem_read_o, wb_reg_write_o, wb_memto_reg_o,
               wb_dst_o, stall_cnt_o
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline: load-use stall, bubble on stall/flush, EX forwarding selects.
// EX outputs one edge after ID capture, WB two edges later; stall is combinational and holds only ID.
module ctrl_pipe #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ctrl_pipe_if.slave  bus
);

    typedef struct packed {
        logic             valid;
        logic             alu_src;
        logic [2:0]       alu_op;
        logic             branch;
        logic             memto_reg;
        logic             reg_write;
        logic             mem_write;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
    } ex_t;

    typedef struct packed {
        logic             valid;
        logic             memto_reg;
        logic             reg_write;
        logic             mem_write;
        logic [REG_W-1:0] dst;
    } mem_t;

    typedef struct packed {
        logic             valid;
        logic             memto_reg;
        logic             reg_write;
        logic [REG_W-1:0] dst;
    } wb_t;

    ex_t              ex_q, ex_d;
    mem_t             mem_q;
    wb_t              wb_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             hazard;
    logic             stall;

    // Jump and ExtOp are consumed upstream of this block; only RegDst..ALUOp matter here.
    logic unused_ctrl;
    assign unused_ctrl = ^bus.id_ctrl_i[4:3];

    always_comb begin
        hazard = ex_q.valid & ex_q.memto_reg & ex_q.reg_write & (ex_q.dst != '0) &
                 ((ex_q.dst == bus.id_rs_i) | (ex_q.dst == bus.id_rt_i));
        stall  = bus.id_valid_i & hazard & ~bus.flush_i;
    end

    always_comb begin
        ex_d = '0;
        if (!(stall || bus.flush_i)) begin
            ex_d.valid     = bus.id_valid_i;
            ex_d.alu_src   = bus.id_ctrl_i[9];
            ex_d.alu_op    = bus.id_ctrl_i[2:0];
            ex_d.memto_reg = bus.id_ctrl_i[8] & bus.id_valid_i;
            ex_d.reg_write = bus.id_ctrl_i[7] & bus.id_valid_i;
            ex_d.mem_write = bus.id_ctrl_i[6] & bus.id_valid_i;
            ex_d.branch    = bus.id_ctrl_i[5] & bus.id_valid_i;
            ex_d.rs        = bus.id_rs_i;
            ex_d.rt        = bus.id_rt_i;
            ex_d.dst       = bus.id_ctrl_i[10] ? bus.id_rd_i : bus.id_rt_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_q            <= ex_d;
            mem_q.valid     <= ex_q.valid;
            mem_q.memto_reg <= ex_q.memto_reg;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_write <= ex_q.mem_write;
            mem_q.dst       <= ex_q.dst;
            wb_q.valid      <= mem_q.valid;
            wb_q.memto_reg  <= mem_q.memto_reg;
            wb_q.reg_write  <= mem_q.reg_write;
            wb_q.dst        <= mem_q.dst;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Youngest producer (EX/MEM) wins; register 0 is hardwired and never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_q.valid && mem_q.reg_write && (mem_q.dst != '0) && (mem_q.dst == src))
            return 2'b10;
        else if (wb_q.valid && wb_q.reg_write && (wb_q.dst != '0) && (wb_q.dst == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign bus.stall_o         = stall;
    assign bus.ex_alu_src_o    = ex_q.alu_src;
    assign bus.ex_alu_op_o     = ex_q.alu_op;
    assign bus.ex_branch_o     = ex_q.branch;
    assign bus.fwd_a_o         = fwd_sel(ex_q.rs);
    assign bus.fwd_b_o         = fwd_sel(ex_q.rt);
    assign bus.mem_mem_write_o = mem_q.mem_write;
    assign bus.mem_mem_read_o  = mem_q.memto_reg;
    assign bus.wb_reg_write_o  = wb_q.reg_write;
    assign bus.wb_memto_reg_o  = wb_q.memto_reg;
    assign bus.wb_dst_o        = wb_q.dst;
    assign bus.stall_cnt_o     = stall_cnt;

endmodule
